// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter sharing an external bank of SR flip-flops: issues one-cycle
// set/reset pulses, reads q back and acks the requester with gnt (err on failure).
module sr_flag_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_FLAGS = 6,
  parameter int IDX_W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       op,
  input  logic [NUM_REQ*IDX_W-1:0] idx,
  input  logic [NUM_FLAGS-1:0]     q_vec,
  output logic [NUM_FLAGS-1:0]     s_vec,
  output logic [NUM_FLAGS-1:0]     r_vec,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     err,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  // Handshake: a requester holds req (with stable op/idx) until it sees its one-cycle gnt;
  // op/idx are latched when the request wins in IDLE and ignored from then on.

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PAD_W = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt;
  logic [PTR_W-1:0]   win, win_nxt;
  logic [PTR_W-1:0]   cand, pick;
  logic               found;
  logic               op_q, op_nxt, pick_op;
  logic [IDX_W-1:0]   idx_q, idx_nxt, pick_idx;
  logic [PAD_W-1:0]   q_pad;
  logic [NUM_FLAGS-1:0] s_nxt, r_nxt;
  logic [NUM_REQ-1:0] gnt_nxt;
  logic               err_nxt;

  // Padding lets an out-of-range index address q safely; such indices never reach it.
  assign q_pad = PAD_W'(q_vec);

  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign pick_op  = op[pick];
  assign pick_idx = idx[int'(pick)*IDX_W +: IDX_W];

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    win_nxt   = win;
    op_nxt    = op_q;
    idx_nxt   = idx_q;
    s_nxt     = '0;
    r_nxt     = '0;
    gnt_nxt   = '0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: if (found) begin
        win_nxt = pick;
        op_nxt  = pick_op;
        idx_nxt = pick_idx;
        if (int'(pick_idx) >= NUM_FLAGS) begin
          state_nxt = ACK;
          gnt_nxt   = NUM_REQ'(1) << pick;
          err_nxt   = 1'b1;
        end else if (q_pad[pick_idx] == pick_op) begin
          state_nxt = ACK;
          gnt_nxt   = NUM_REQ'(1) << pick;
        end else begin
          state_nxt = ISSUE;
          if (pick_op) s_nxt = NUM_FLAGS'(1) << pick_idx;
          else         r_nxt = NUM_FLAGS'(1) << pick_idx;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        // The bank took the pulse at the end of ISSUE, so q is valid here.
        state_nxt = ACK;
        gnt_nxt   = NUM_REQ'(1) << win;
        err_nxt   = (q_pad[idx_q] != op_q);
      end
      ACK: begin
        state_nxt = IDLE;
        ptr_nxt   = PTR_W'((int'(win) + 1) % NUM_REQ);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      op_q  <= 1'b0;
      idx_q <= '0;
      s_vec <= '0;
      r_vec <= '0;
      gnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      win   <= win_nxt;
      op_q  <= op_nxt;
      idx_q <= idx_nxt;
      s_vec <= s_nxt;
      r_vec <= r_nxt;
      gnt   <= gnt_nxt;
      err   <= err_nxt;
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Bench for sr_flag_arbiter: SR bank model, transaction-level reference schedule,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sr_flag_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int NUM_FLAGS = 6;
  localparam int IDX_W     = 3;
  localparam int MAXC      = 4096;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       op;
  logic [NUM_REQ*IDX_W-1:0] idx;
  logic [NUM_FLAGS-1:0]     q_vec;
  logic [NUM_FLAGS-1:0]     s_vec, r_vec;
  logic [NUM_REQ-1:0]       gnt;
  logic                     err, busy;
  logic [1:0]               dbg_state;

  sr_flag_arbiter #(.NUM_REQ(NUM_REQ), .NUM_FLAGS(NUM_FLAGS), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .q_vec(q_vec),
    .s_vec(s_vec), .r_vec(r_vec), .gnt(gnt), .err(err), .busy(busy),
    .dbg_state(dbg_state)
  );

  // external SR bank with optional stuck-at-0 flags and a preload path
  logic [NUM_FLAGS-1:0] bank_q, bank_val, stuck;
  logic                 bank_load;
  assign q_vec = bank_q;

  always @(posedge clk) begin
    if (bank_load) bank_q <= bank_val;
    else begin
      for (int i = 0; i < NUM_FLAGS; i++) begin
        if (s_vec[i] && !stuck[i]) bank_q[i] <= 1'b1;
        else if (r_vec[i])         bank_q[i] <= 1'b0;
      end
    end
  end

  // scoreboard
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit started = 1'b0;

  logic [NUM_FLAGS-1:0] exp_s    [MAXC];
  logic [NUM_FLAGS-1:0] exp_r    [MAXC];
  logic [NUM_REQ-1:0]   exp_gnt  [MAXC];
  logic                 exp_err  [MAXC];
  logic                 exp_busy [MAXC];

  int   m_ptr = 0;
  int   m_free = 0;
  int   m_w, m_ix;
  logic m_o;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  task automatic clear_slot(input int c);
    if (c < MAXC) begin
      exp_s[c] = '0; exp_r[c] = '0; exp_gnt[c] = '0; exp_err[c] = 1'b0; exp_busy[c] = 1'b0;
    end
  endtask

  // compare + reference model, evaluated mid-cycle on the falling edge
  initial begin
    for (int i = 0; i < MAXC; i++) clear_slot(i);
    forever begin
      @(negedge clk);
      if (started && cyc < MAXC) begin
        check("s_vec", 32'(s_vec), 32'(exp_s[cyc]));
        check("r_vec", 32'(r_vec), 32'(exp_r[cyc]));
        check("gnt",   32'(gnt),   32'(exp_gnt[cyc]));
        check("err",   32'(err),   32'(exp_err[cyc]));
        check("busy",  32'(busy),  32'(exp_busy[cyc]));
        check("s_and_r", 32'(s_vec & r_vec), 32'd0);
      end
      if (rst) begin
        started = 1'b1;
        for (int j = 1; j <= 4; j++) clear_slot(cyc + j);
        m_ptr  = 0;
        m_free = cyc + 1;
      end else if (started && cyc >= m_free && req != '0 && cyc + 4 < MAXC) begin
        m_w = -1;
        for (int k = 0; k < NUM_REQ; k++)
          if (m_w < 0 && req[(m_ptr + k) % NUM_REQ]) m_w = (m_ptr + k) % NUM_REQ;
        m_o   = op[m_w];
        m_ix  = int'(idx[m_w*IDX_W +: IDX_W]);
        m_ptr = (m_w + 1) % NUM_REQ;
        if (m_ix >= NUM_FLAGS || q_vec[m_ix] == m_o) begin
          exp_busy[cyc+1] = 1'b1;
          exp_gnt[cyc+1]  = NUM_REQ'(1 << m_w);
          exp_err[cyc+1]  = (m_ix >= NUM_FLAGS);
          m_free = cyc + 2;
        end else begin
          if (m_o) exp_s[cyc+1][m_ix] = 1'b1;
          else     exp_r[cyc+1][m_ix] = 1'b1;
          for (int j = 1; j <= 3; j++) exp_busy[cyc+j] = 1'b1;
          exp_gnt[cyc+3] = NUM_REQ'(1 << m_w);
          exp_err[cyc+3] = m_o && stuck[m_ix];
          m_free = cyc + 4;
        end
      end
      cyc++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int k, input logic o, input int ix);
    req[k] = 1'b1;
    op[k]  = o;
    idx[k*IDX_W +: IDX_W] = IDX_W'(ix);
  endtask

  logic [NUM_REQ-1:0] gq[$];

  initial begin
    rst = 1'b1; req = 4'hF; op = 4'b0001; idx = {3'd3, 3'd1, 3'd0, 3'd2};
    bank_load = 1'b1; bank_val = '0; stuck = '0;

    // reset held two cycles with all requests high
    step(); bank_load = 1'b0;
    check("rst_s",    32'(s_vec), 0);
    step();
    check("rst_busy", 32'(busy), 0);
    check("rst_gnt",  32'(gnt), 0);
    check("rst_r",    32'(r_vec), 0);
    rst = 1'b0;

    // requester 0 sets flag 2 first, then round robin with all requests held
    step(); check("set2_pulse", 32'(s_vec), 32'b000100);
    step(); check("set2_q", 32'(q_vec[2]), 1); check("set2_s_gone", 32'(s_vec), 0);
    step(); check("set2_gnt", 32'(gnt), 32'b0001); check("set2_err", 32'(err), 0);
    op[0] = 1'b0;
    gq.delete();
    for (int i = 0; i < 10; i++) begin
      step();
      if (gnt != '0) gq.push_back(gnt);
    end
    check("rr_count", gq.size(), 4);
    if (gq.size() == 4) begin
      check("rr_1", 32'(gq[0]), 32'b0010);
      check("rr_2", 32'(gq[1]), 32'b0100);
      check("rr_3", 32'(gq[2]), 32'b1000);
      check("rr_4", 32'(gq[3]), 32'b0001);
    end
    req = '0;
    step(); step();

    // skip path: flag 3 already set
    bank_load = 1'b1; bank_val = 6'b001000;
    step(); bank_load = 1'b0;
    set_req(2, 1'b1, 3);
    step();
    check("skip_gnt", 32'(gnt), 32'b0100); check("skip_err", 32'(err), 0);
    check("skip_s", 32'(s_vec), 0);        check("skip_r", 32'(r_vec), 0);
    req = '0;
    step();

    // out-of-range index
    set_req(1, 1'b1, 7);
    step();
    check("range_gnt", 32'(gnt), 32'b0010); check("range_err", 32'(err), 1);
    check("range_s", 32'(s_vec), 0);
    req = '0;
    step();

    // flag 1 stuck at 0: set fails
    stuck = 6'b000010;
    set_req(1, 1'b1, 1);
    step(); check("stuck_pulse", 32'(s_vec), 32'b000010);
    step(); check("stuck_q", 32'(q_vec[1]), 0);
    step(); check("stuck_gnt", 32'(gnt), 32'b0010); check("stuck_err", 32'(err), 1);
    req = '0;
    step(); stuck = '0;

    // reset during ISSUE drops the op; held request is re-arbitrated
    set_req(3, 1'b1, 4);
    step(); check("abort_pulse", 32'(s_vec), 32'b010000);
    rst = 1'b1;
    step();
    check("abort_s", 32'(s_vec), 0); check("abort_gnt", 32'(gnt), 0);
    check("abort_busy", 32'(busy), 0);
    rst = 1'b0;
    step(); check("rearb_gnt", 32'(gnt), 32'b1000); check("rearb_err", 32'(err), 0);
    req = '0;
    step(); step();

    // randomized traffic
    stuck = 6'b100000;
    for (int n = 0; n < 3000; n++) begin
      step();
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req[k] && gnt[k]) req[k] = 1'b0;
        else if (!req[k]) begin
          if ($urandom_range(0, 3) == 0) set_req(k, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
        end else if ($urandom_range(0, 15) == 0) begin
          op[k] = 1'($urandom_range(0, 1));
          idx[k*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, 7));
        end
      end
    end
    rst = 1'b0; req = '0;
    for (int i = 0; i < 6; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
